// File: rtl/mig1_pkg.sv
// Shared Mig1 fetch types: instruction word, fetch FSM states and the queue entry layout
// (entry shown at the default 32-bit byte-address width).
package mig1_pkg;

  localparam int INSN_SIZE        = 4;
  localparam int DATA_WIDTH       = 32;
  localparam int DEF_ADDR_WIDTH   = 32;

  typedef logic [DATA_WIDTH-1:0] insn_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    insn_t                     data;
    logic [DEF_ADDR_WIDTH-1:2] pc;
    logic                      err;
  } fetch_entry_t;

endpackage

// File: rtl/mig1_insn_fetch_if.sv
// Memory request/response and decode hand-off signals of the fetch stage. The master side is the
// fetch stage; the slave side is memory plus decode.
interface mig1_insn_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  import mig1_pkg::*;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:2] mem_req_addr;
  logic                  mem_rsp_valid;
  insn_t                 mem_rsp_data;
  logic                  mem_rsp_err;
  logic                  insn_valid;
  logic                  insn_ready;
  insn_t                 insn_data;
  logic [ADDR_WIDTH-1:2] insn_pc;
  logic                  insn_err;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output insn_valid, insn_data, insn_pc, insn_err,
    input  insn_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  insn_valid, insn_data, insn_pc, insn_err,
    output insn_ready
  );

endinterface

// File: rtl/mig1_fifo.sv
// Small synchronous FIFO with a registered head word, so the head is valid the cycle after a push
// into an empty queue.
module mig1_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_nxt;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dout_q;

  assign rd_nxt = rd_ptr_q + PW'(1);

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_nxt;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Head register follows the next-oldest entry on a pop, or takes din when it becomes the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (!flush) begin
      if (pop && (count_q > CW'(1))) begin
        dout_q <= mem_q[rd_nxt];
      end else if (push && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
        dout_q <= din;
      end
    end
  end

  assign dout  = dout_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mig1_insn_fetch.sv
// Mig1 instruction fetch: issues word reads while queue credit allows, queues in-order responses
// with their PC, and hands them to decode; a redirect flushes and restarts.
module mig1_insn_fetch
  import mig1_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:2] rst_addr,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:2] redirect_addr,
  mig1_insn_fetch_if.master     bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int PW = ADDR_WIDTH - 2;

  typedef struct packed {
    insn_t                 data;
    logic [ADDR_WIDTH-1:2] pc;
    logic                  err;
  } entry_t;

  localparam int EW = $bits(entry_t);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:2] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:2] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         q_count;
  logic [CW:0]           owed;
  logic                  req_valid, req_fire;
  logic                  q_push, q_pop, q_full, q_empty;
  entry_t                push_entry, head;
  logic [EW-1:0]         fifo_dout;

  // Words owed to decode: queued plus live (non-dropped) reads in flight.
  assign owed       = {1'b0, q_count} + {1'b0, inflight_q} - {1'b0, drop_q};
  assign req_fire   = req_valid & bus.mem_req_ready;
  assign q_push     = bus.mem_rsp_valid & (drop_q == '0) & ~redirect_valid;
  assign q_pop      = ~q_empty & bus.insn_ready & ~redirect_valid;
  assign push_entry = {bus.mem_rsp_data, rsp_pc_q, bus.mem_rsp_err};
  assign head       = fifo_dout;

  mig1_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (q_push),
    .din   (push_entry),
    .pop   (q_pop),
    .dout  (fifo_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = fetch_en ? FETCH : IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (fetch_en) state_d = FETCH;
        FETCH: begin
          if (q_push && bus.mem_rsp_err) state_d = HALT;
          else if (!fetch_en)            state_d = IDLE;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_valid = 1'b0;
    if ((state_q == FETCH) && !redirect_valid && (owed < (CW+1)'(QUEUE_DEPTH))) begin
      req_valid = 1'b1;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(bus.mem_rsp_valid);
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
      rsp_pc_d   = redirect_addr;
      drop_d     = inflight_q + CW'(req_fire) - CW'(bus.mem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PW'(1);
      if (q_push)   rsp_pc_d   = rsp_pc_q + PW'(1);
      if (bus.mem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= rst_addr;
      rsp_pc_q   <= rst_addr;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(q_push && q_full && !q_pop));
      assert (inflight_q <= CW'(QUEUE_DEPTH));
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.insn_valid    = ~q_empty;
  assign bus.insn_data     = head.data;
  assign bus.insn_pc       = head.pc;
  assign bus.insn_err      = head.err;

endmodule

// File: tb/tb_mig1_insn_fetch.sv
// Directed + randomized bench for mig1_insn_fetch: an in-order memory responder and a decode sink
// are checked against a word-stream model (PCs count up from the last restart address).
module tb_mig1_insn_fetch;
  import mig1_pkg::*;

  localparam int AW = 32;
  localparam int QD = 2;
  localparam int PW = AW - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] rst_addr;
  logic          fetch_en;
  logic          redirect_valid;
  logic [PW-1:0] redirect_addr;

  always #5 clk = ~clk;

  mig1_insn_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  mig1_insn_fetch #(
    .ADDR_WIDTH  (AW),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rst_addr       (rst_addr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus)
  );

  typedef struct {
    int            gen;
    logic [PW-1:0] addr;
  } pend_t;

  pend_t         pend[$];
  int            n_pass = 0, n_checks = 0, n_fail = 0;
  int            gen = 0, q_model = 0, live_out = 0;
  int            n_acc = 0, n_pops = 0;
  logic [PW-1:0] exp_req_addr, exp_pop_pc, first_pop_pc, err_pop_pc, err_addr;
  bit            running = 0, halted = 0, err_en = 0;
  bit            first_seen = 0, err_seen = 0, saw_pc0 = 0;
  int            ready_pct = 100, rsp_pct = 100, insn_pct = 100;

  function automatic insn_t dfun(logic [PW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit efun(logic [PW-1:0] a);
    return err_en && (a == err_addr);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(logic [PW-1:0] a);
    rst = 1'b1;
    rst_addr = a;
    redirect_valid = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.insn_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    gen++;
    q_model = 0; live_out = 0;
    exp_req_addr = a; exp_pop_pc = a;
    running = 0; halted = 0;
    #1;
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_insn_valid", bus.insn_valid, 0);
    chk("rst_req_addr", bus.mem_req_addr, a);
    chk("rst_insn_data", bus.insn_data, 0);
    chk("rst_insn_pc", bus.insn_pc, 0);
    chk("rst_insn_err", bus.insn_err, 0);
  endtask

  // One clock: drive responder/sinks, check against the model, then advance past the edge.
  task automatic cyc();
    pend_t f, nf;
    bit rsp_now, acc, pop_now, halt_now;
    rsp_now = (pend.size() > 0) && ($urandom_range(99) < rsp_pct);
    bus.mem_rsp_valid = rsp_now;
    if (rsp_now) begin
      bus.mem_rsp_data = dfun(pend[0].addr);
      bus.mem_rsp_err  = efun(pend[0].addr);
    end else begin
      bus.mem_rsp_data = $urandom;
      bus.mem_rsp_err  = 1'($urandom_range(1));
    end
    bus.mem_req_ready = ($urandom_range(99) < ready_pct);
    bus.insn_ready    = ($urandom_range(99) < insn_pct);
    #1;
    chk("req_valid", bus.mem_req_valid,
        running && !halted && !redirect_valid && ((q_model + live_out) < QD));
    chk("insn_valid", bus.insn_valid, q_model > 0);
    acc     = bus.mem_req_valid && bus.mem_req_ready;
    pop_now = (q_model > 0) && bus.insn_ready && !redirect_valid;
    if (pop_now) begin
      chk("insn_pc", bus.insn_pc, exp_pop_pc);
      chk("insn_data", bus.insn_data, dfun(exp_pop_pc));
      chk("insn_err", bus.insn_err, efun(exp_pop_pc));
      if (!first_seen) begin first_seen = 1; first_pop_pc = bus.insn_pc; end
      if (bus.insn_err && !err_seen) begin err_seen = 1; err_pop_pc = bus.insn_pc; end
      if (bus.insn_pc == '0) saw_pc0 = 1;
      exp_pop_pc++;
      q_model--;
      n_pops++;
    end
    halt_now = 0;
    if (rsp_now) begin
      f = pend.pop_front();
      if (!redirect_valid && (f.gen == gen)) begin
        live_out--;
        q_model++;
        if (running && !halted && efun(f.addr)) halt_now = 1;
      end
    end
    if (acc) begin
      chk("req_addr", bus.mem_req_addr, exp_req_addr);
      nf.gen  = gen;
      nf.addr = bus.mem_req_addr;
      pend.push_back(nf);
      exp_req_addr++;
      live_out++;
      n_acc++;
    end
    if (redirect_valid) begin
      gen++;
      q_model = 0; live_out = 0;
      exp_req_addr = redirect_addr; exp_pop_pc = redirect_addr;
      halted = 0;
      running = fetch_en;
    end else begin
      if (halt_now) halted = 1;
      if (!halted) running = fetch_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(logic [PW-1:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    first_seen = 0;
    cyc();
    redirect_valid = 1'b0;
  endtask

  logic [PW-1:0] stall_addr;

  initial begin
    rst = 1'b1; rst_addr = '0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    bus.mem_rsp_err = 1'b0; bus.insn_ready = 1'b0;

    // 1: streaming at full rate
    do_reset(30'h100);
    n_pops = 0; first_seen = 0;
    repeat (20) cyc();
    chk("t1_first_pc", first_pop_pc, 30'h100);
    chk("t1_pops_seen", n_pops > 5, 1);

    // 2: decode stalled, only QD reads issued; then release; then fetch_en low
    do_reset(30'h100);
    n_acc = 0; insn_pct = 0;
    repeat (10) cyc();
    chk("t2_reqs_capped", n_acc, QD);
    insn_pct = 100;
    repeat (10) cyc();
    chk("t2_reqs_resumed", n_acc > QD, 1);
    fetch_en = 1'b0;
    repeat (6) cyc();
    fetch_en = 1'b1;
    repeat (6) cyc();

    // 3: redirect with two reads in flight
    do_reset(30'h100);
    n_acc = 0; rsp_pct = 0;
    repeat (4) cyc();
    chk("t3_two_inflight", n_acc, 2);
    rsp_pct = 100;
    redirect(30'h200);
    chk("t3_queue_empty", bus.insn_valid, 0);
    repeat (12) cyc();
    chk("t3_first_seen", first_seen, 1);
    chk("t3_first_pc", first_pop_pc, 30'h200);

    // 4: bus error halts fetch until redirect
    err_en = 1; err_addr = 30'h104; err_seen = 0;
    do_reset(30'h100);
    repeat (30) cyc();
    chk("t4_err_seen", err_seen, 1);
    chk("t4_err_pc", err_pop_pc, 30'h104);
    chk("t4_halted_no_req", bus.mem_req_valid, 0);
    err_en = 0;
    n_pops = 0;
    redirect(30'h300);
    repeat (15) cyc();
    chk("t4_restart_pc", first_pop_pc, 30'h300);
    chk("t4_restart_pops", n_pops > 0, 1);

    // 5: PC wrap
    saw_pc0 = 0;
    redirect(30'h3FFF_FFFE);
    repeat (15) cyc();
    chk("t5_wrap_pc0", saw_pc0, 1);

    // 6: request stall, then reset mid-stall
    do_reset(30'h400);
    ready_pct = 0;
    cyc();
    stall_addr = bus.mem_req_addr;
    repeat (5) begin
      cyc();
      chk("t6_stall_valid", bus.mem_req_valid, 1);
      chk("t6_stall_addr", bus.mem_req_addr, stall_addr);
    end
    ready_pct = 100;
    do_reset(30'h180);

    // randomized traffic with random redirects and error addresses
    for (int seg = 0; seg < 10; seg++) begin
      ready_pct = $urandom_range(30, 100);
      rsp_pct   = $urandom_range(30, 100);
      insn_pct  = $urandom_range(20, 100);
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(99) < 3) begin
          redirect_valid = 1'b1;
          redirect_addr  = ($urandom_range(3) == 0) ? PW'(30'h3FFF_FFFC + $urandom_range(3))
                                                    : PW'($urandom);
          err_en   = ($urandom_range(2) == 0);
          err_addr = redirect_addr + PW'($urandom_range(5));
          first_seen = 0;
        end
        cyc();
        redirect_valid = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
